// File: rtl/dcpu16_mem_arb_if.sv
// Generic stb/ack bus used for both CPU-side slaves and the memory-side master.
// The master drives the request fields; the slave returns read data and the ack pulse.
interface dcpu16_mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] adr;
    logic [DW-1:0] dto;
    logic          stb;
    logic          wre;
    logic [DW-1:0] dti;
    logic          ack;

    modport master (output adr, output dto, output stb, output wre, input dti, input ack);
    modport slave  (input adr, input dto, input stb, input wre, output dti, output ack);
endinterface

// File: rtl/dcpu16_mem_arb.sv
// Shares one single-port stb/ack memory between the dcpu16 fetch (fs) and data (ab) buses.
// One transfer in flight at a time; round-robin or fixed ab priority; optional ack watchdog.
module dcpu16_mem_arb #(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int FIXP = 0,
    parameter int TMO  = 64
) (
    input  logic                clk,
    input  logic                rst,
    dcpu16_mem_arb_if.slave     fs,
    dcpu16_mem_arb_if.slave     ab,
    dcpu16_mem_arb_if.master    mm,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TMO_LAST = (TMO == 0) ? 8'd0 : 8'(TMO - 1);

    // gnt/last encoding: 0 = fs, 1 = ab
    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [AW-1:0] mm_adr_q, mm_adr_d;
    logic [DW-1:0] mm_dto_q, mm_dto_d;
    logic          mm_stb_q, mm_stb_d;
    logic          mm_wre_q, mm_wre_d;
    logic [DW-1:0] fs_dti_q, fs_dti_d;
    logic [DW-1:0] ab_dti_q, ab_dti_d;
    logic          fs_ack_q, fs_ack_d;
    logic          ab_ack_q, ab_ack_d;
    logic          err_q, err_d;
    logic          win;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        tmo_d    = tmo_q;
        mm_adr_d = mm_adr_q;
        mm_dto_d = mm_dto_q;
        mm_stb_d = mm_stb_q;
        mm_wre_d = mm_wre_q;
        fs_dti_d = fs_dti_q;
        ab_dti_d = ab_dti_q;
        fs_ack_d = 1'b0;
        ab_ack_d = 1'b0;
        err_d    = 1'b0;
        win      = (ab.stb && !fs.stb) ||
                   (ab.stb && fs.stb && ((FIXP != 0) || !last_q));
        case (state_q)
            IDLE: begin
                if (fs.stb || ab.stb) begin
                    mm_adr_d = win ? ab.adr : fs.adr;
                    mm_dto_d = win ? ab.dto : fs.dto;
                    mm_wre_d = win ? ab.wre : fs.wre;
                    mm_stb_d = 1'b1;
                    gnt_d    = win;
                    tmo_d    = 8'd0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (mm.ack || ((TMO != 0) && (tmo_q == TMO_LAST))) begin
                    // An aborted transfer still acks the requester, with zero data.
                    mm_stb_d = 1'b0;
                    mm_wre_d = 1'b0;
                    err_d    = !mm.ack;
                    if (gnt_q) begin
                        ab_ack_d = 1'b1;
                        ab_dti_d = mm.ack ? mm.dti : '0;
                    end else begin
                        fs_ack_d = 1'b1;
                        fs_dti_d = mm.ack ? mm.dti : '0;
                    end
                    last_d  = gnt_q;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            tmo_q    <= 8'd0;
            mm_adr_q <= '0;
            mm_dto_q <= '0;
            mm_stb_q <= 1'b0;
            mm_wre_q <= 1'b0;
            fs_dti_q <= '0;
            ab_dti_q <= '0;
            fs_ack_q <= 1'b0;
            ab_ack_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            tmo_q    <= tmo_d;
            mm_adr_q <= mm_adr_d;
            mm_dto_q <= mm_dto_d;
            mm_stb_q <= mm_stb_d;
            mm_wre_q <= mm_wre_d;
            fs_dti_q <= fs_dti_d;
            ab_dti_q <= ab_dti_d;
            fs_ack_q <= fs_ack_d;
            ab_ack_q <= ab_ack_d;
            err_q    <= err_d;
        end
    end

    assign mm.adr = mm_adr_q;
    assign mm.dto = mm_dto_q;
    assign mm.stb = mm_stb_q;
    assign mm.wre = mm_wre_q;
    assign fs.dti = fs_dti_q;
    assign fs.ack = fs_ack_q;
    assign ab.dti = ab_dti_q;
    assign ab.ack = ab_ack_q;
    assign err    = err_q;
endmodule

// File: tb/tb_dcpu16_mem_arb.sv
// Bench for dcpu16_mem_arb: round-robin/watchdog instance (u0) and fixed-priority instance (u1),
// each behind a behavioural single-port memory that acks one cycle after seeing stb.
module tb_dcpu16_mem_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err0, err1;
    logic noack0 = 1'b0, spur0 = 1'b0;
    int   cmp = 0, bad = 0;

    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];
    logic [15:0] ref_mem [0:65535];

    dcpu16_mem_arb_if #(.AW(16), .DW(16)) fs0(), ab0(), mm0(), fs1(), ab1(), mm1();

    dcpu16_mem_arb #(.AW(16), .DW(16), .FIXP(0), .TMO(8)) u0 (
        .clk(clk), .rst(rst), .fs(fs0.slave), .ab(ab0.slave), .mm(mm0.master), .err(err0));
    dcpu16_mem_arb #(.AW(16), .DW(16), .FIXP(1), .TMO(8)) u1 (
        .clk(clk), .rst(rst), .fs(fs1.slave), .ab(ab1.slave), .mm(mm1.master), .err(err1));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            mm0.ack <= 1'b0; mm0.dti <= 16'h0;
        end else begin
            mm0.ack <= spur0 | (mm0.stb & ~mm0.ack & ~noack0);
            if (mm0.stb && !mm0.ack && !noack0) begin
                mm0.dti <= mem0[mm0.adr];
                if (mm0.wre) mem0[mm0.adr] <= mm0.dto;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            mm1.ack <= 1'b0; mm1.dti <= 16'h0;
        end else begin
            mm1.ack <= mm1.stb & ~mm1.ack;
            if (mm1.stb && !mm1.ack) begin
                mm1.dti <= mem1[mm1.adr];
                if (mm1.wre) mem1[mm1.adr] <= mm1.dto;
            end
        end
    end

    // One transfer on u0 (port 0 = fs, 1 = ab); reports what was seen, no judging here.
    task automatic do_xfer0(input bit port, input bit wre, input logic [15:0] adr, input logic [15:0] dto,
                            output logic [15:0] dti, output bit ok, output logic [15:0] madr,
                            output bit mwre, output logic [15:0] mdto, output int scyc,
                            output bit other, output bit single, output bit errs);
        bit seen = 0;
        ok = 0; scyc = 0; other = 0; single = 0; errs = 0; dti = 0; madr = 0; mwre = 0; mdto = 0;
        @(negedge clk);
        if (port) begin ab0.adr = adr; ab0.dto = dto; ab0.wre = wre; ab0.stb = 1'b1; end
        else      begin fs0.adr = adr; fs0.dto = dto; fs0.wre = wre; fs0.stb = 1'b1; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mm0.stb) begin
                scyc++;
                if (!seen) begin seen = 1; madr = mm0.adr; mwre = mm0.wre; mdto = mm0.dto; end
            end
            if (port ? fs0.ack : ab0.ack) other = 1;
            if (port ? ab0.ack : fs0.ack) begin
                ok = 1; errs = err0; dti = port ? ab0.dti : fs0.dti;
                break;
            end
        end
        if (port) begin ab0.stb = 1'b0; ab0.wre = 1'b0; end
        else      begin fs0.stb = 1'b0; fs0.wre = 1'b0; end
        @(negedge clk);
        single = !(port ? ab0.ack : fs0.ack);
    endtask

    task automatic test_reset;
        @(negedge clk);
        cmp++;
        if ({mm0.stb, mm0.wre, mm0.adr, mm0.dto, fs0.ack, ab0.ack, fs0.dti, ab0.dti, err0} !== '0) begin
            bad++;
            $display("FAIL reset_u0: got stb=%b wre=%b adr=%h dto=%h fack=%b aack=%b fdti=%h adti=%h err=%b, want all 0",
                     mm0.stb, mm0.wre, mm0.adr, mm0.dto, fs0.ack, ab0.ack, fs0.dti, ab0.dti, err0);
        end
        cmp++;
        if ({mm1.stb, mm1.wre, fs1.ack, ab1.ack, err1} !== '0) begin
            bad++; $display("FAIL reset_u1: outputs not 0 (stb=%b ack=%b/%b err=%b)", mm1.stb, fs1.ack, ab1.ack, err1);
        end
        rst = 1'b1;
    endtask

    task automatic test_fs_read;
        logic [15:0] dti, madr, mdto; bit ok, mwre, other, single, errs; int scyc;
        do_xfer0(0, 0, 16'h0010, 16'h0, dti, ok, madr, mwre, mdto, scyc, other, single, errs);
        cmp++; if (!ok) begin bad++; $display("FAIL fs_read_ack: no fs_ack within budget"); end
        cmp++; if (madr !== 16'h0010 || mwre !== 1'b0) begin bad++; $display("FAIL fs_read_mm: adr=%h wre=%b want 0010/0", madr, mwre); end
        cmp++; if (dti !== 16'hBEEF) begin bad++; $display("FAIL fs_read_dti: got %h want beef", dti); end
        cmp++; if (other || !single) begin bad++; $display("FAIL fs_read_pulse: ab_ack=%b single=%b want 0/1", other, single); end
        cmp++; if (scyc != 2) begin bad++; $display("FAIL fs_read_lat: mm_stb cycles %0d want 2", scyc); end
    endtask

    task automatic test_ab_write;
        logic [15:0] dti, madr, mdto; bit ok, mwre, other, single, errs; int scyc;
        do_xfer0(1, 1, 16'h8000, 16'h1234, dti, ok, madr, mwre, mdto, scyc, other, single, errs);
        ref_mem[16'h8000] = 16'h1234;
        cmp++; if (!ok || !single || other) begin bad++; $display("FAIL ab_write_ack: ok=%b single=%b fs_ack=%b want 1/1/0", ok, single, other); end
        cmp++; if (madr !== 16'h8000 || mwre !== 1'b1 || mdto !== 16'h1234) begin
            bad++; $display("FAIL ab_write_mm: adr=%h wre=%b dto=%h want 8000/1/1234", madr, mwre, mdto); end
        do_xfer0(0, 0, 16'h8000, 16'h0, dti, ok, madr, mwre, mdto, scyc, other, single, errs);
        cmp++; if (!ok || dti !== 16'h1234) begin bad++; $display("FAIL ab_write_readback: ok=%b got %h want 1234", ok, dti); end
    endtask

    task automatic test_random;
        logic [15:0] dti, madr, mdto, adr, dto; bit ok, mwre, other, single, errs, port, wre; int scyc;
        for (int n = 0; n < 24; n++) begin
            port = 1'($urandom_range(0, 1));
            wre  = 1'($urandom_range(0, 1));
            adr  = 16'h0040 + 16'($urandom_range(0, 15));
            dto  = 16'($urandom);
            do_xfer0(port, wre, adr, dto, dti, ok, madr, mwre, mdto, scyc, other, single, errs);
            cmp++;
            if (!ok || !single || other || errs || madr !== adr || mwre !== wre || (wre && mdto !== dto) ||
                (!wre && dti !== ref_mem[adr])) begin
                bad++;
                $display("FAIL random_%0d: port=%0d wre=%b adr=%h ok=%b single=%b other=%b err=%b madr=%h mwre=%b mdto=%h dti=%h want dto=%h rd=%h",
                         n, port, wre, adr, ok, single, other, errs, madr, mwre, mdto, dti, dto, ref_mem[adr]);
            end
            if (wre) ref_mem[adr] = dto;
        end
    endtask

    task automatic test_spurious_ack;
        bit any = 0;
        @(negedge clk); spur0 = 1'b1;
        @(negedge clk); spur0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fs0.ack || ab0.ack || mm0.stb || err0) any = 1;
        end
        cmp++; if (any) begin bad++; $display("FAIL spurious_ack: activity seen=1 want 0"); end
    endtask

    task automatic test_drop_stb;
        bit got = 0, go = 0; logic [15:0] dti = 0;
        @(negedge clk); fs0.adr = 16'h0010; fs0.wre = 1'b0; fs0.stb = 1'b1;
        for (int i = 0; i < 20 && !go; i++) begin @(negedge clk); if (mm0.stb) go = 1; end
        fs0.stb = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (fs0.ack) begin got = 1; dti = fs0.dti; end end
        cmp++; if (!got || dti !== 16'hBEEF) begin bad++; $display("FAIL drop_stb: ack=%b dti=%h want 1/beef", got, dti); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        logic [15:0] dti, madr, mdto; bit ok, mwre, other, single, errs; int scyc;
        noack0 = 1'b1;
        do_xfer0(0, 0, 16'h0010, 16'h0, dti, ok, madr, mwre, mdto, scyc, other, single, errs);
        cmp++; if (scyc != 8) begin bad++; $display("FAIL timeout_stb: mm_stb high %0d cycles want 8", scyc); end
        cmp++; if (!ok || !errs || dti !== 16'h0000) begin bad++; $display("FAIL timeout_ack: ack=%b err=%b dti=%h want 1/1/0000", ok, errs, dti); end
        cmp++; if (!single || err0) begin bad++; $display("FAIL timeout_pulse: single=%b err_after=%b want 1/0", single, err0); end
        noack0 = 1'b0;
        do_xfer0(0, 0, 16'h0010, 16'h0, dti, ok, madr, mwre, mdto, scyc, other, single, errs);
        cmp++; if (!ok || errs || dti !== 16'hBEEF) begin bad++; $display("FAIL timeout_recover: ok=%b err=%b dti=%h want 1/0/beef", ok, errs, dti); end
    endtask

    // Both ports hold stb from reset; the model predicts each grant from the arbitration rule.
    task automatic test_contention;
        bit last_ab = 1, exp_ab, pf = 0, pa = 0, fin = 0; int got = 0;
        @(negedge clk); rst = 1'b0;
        fs0.adr = 16'h0100; fs0.wre = 0; ab0.adr = 16'h0200; ab0.wre = 0;
        fs0.stb = 1'b1; ab0.stb = 1'b1;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if ((fs0.ack && (pf || ab0.ack)) || (ab0.ack && pa)) begin
                cmp++; bad++; $display("FAIL contention_pulse: fs_ack=%b ab_ack=%b prev=%b/%b", fs0.ack, ab0.ack, pf, pa);
            end
            if (fs0.ack || ab0.ack) begin
                exp_ab = !last_ab; last_ab = exp_ab;
                cmp++;
                if (ab0.ack !== exp_ab) begin bad++; $display("FAIL contention_order_%0d: got %s want %s", got, ab0.ack ? "ab" : "fs", exp_ab ? "ab" : "fs"); end
                got++;
                if (got == 8) fin = 1;
            end
            pf = fs0.ack; pa = ab0.ack;
        end
        cmp++; if (!fin) begin bad++; $display("FAIL contention_budget: %0d acks want 8", got); end
        fs0.stb = 1'b0; ab0.stb = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fixp;
        int ab_left = 4, fs_left = 4, got = 0; bit exp_ab;
        @(negedge clk); rst = 1'b0;
        fs1.adr = 16'h0300; fs1.wre = 0; fs1.dto = 0; ab1.adr = 16'h0400; ab1.wre = 0; ab1.dto = 0;
        fs1.stb = 1'b1; ab1.stb = 1'b1;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 200 && got < 8; i++) begin
            @(negedge clk);
            if (fs1.ack && ab1.ack) begin cmp++; bad++; $display("FAIL fixp_both: fs_ack and ab_ack together"); end
            if (fs1.ack || ab1.ack) begin
                exp_ab = (ab_left > 0);
                cmp++;
                if (ab1.ack !== exp_ab) begin bad++; $display("FAIL fixp_order_%0d: got %s want %s", got, ab1.ack ? "ab" : "fs", exp_ab ? "ab" : "fs"); end
                if (ab1.ack) ab_left--; else fs_left--;
                if (ab_left == 0) ab1.stb = 1'b0;
                if (fs_left == 0) fs1.stb = 1'b0;
                got++;
            end
        end
        cmp++; if (got != 8) begin bad++; $display("FAIL fixp_budget: %0d acks want 8", got); end
        fs1.stb = 1'b0; ab1.stb = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit busy = 0, got = 0, first_ab = 1;
        noack0 = 1'b1;
        @(negedge clk); ab0.adr = 16'h0500; ab0.wre = 1'b0; ab0.stb = 1'b1;
        repeat (3) @(negedge clk);
        busy = mm0.stb;
        cmp++; if (!busy) begin bad++; $display("FAIL reset_mid_busy: mm_stb=%b want 1", mm0.stb); end
        #1 rst = 1'b0;
        #1;
        cmp++;
        if (mm0.stb || fs0.ack || ab0.ack || err0) begin
            bad++; $display("FAIL reset_mid_drop: stb=%b fack=%b aack=%b err=%b want 0", mm0.stb, fs0.ack, ab0.ack, err0);
        end
        noack0 = 1'b0;
        fs0.adr = 16'h0010; fs0.wre = 1'b0; fs0.stb = 1'b1;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (fs0.ack || ab0.ack) begin got = 1; first_ab = ab0.ack; end
        end
        cmp++; if (!got || first_ab) begin bad++; $display("FAIL reset_mid_first: got=%b first=%s want fs", got, first_ab ? "ab" : "fs"); end
        fs0.stb = 1'b0; ab0.stb = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem0[a] = 16'(a * 7 + 3); mem1[a] = 16'(a); ref_mem[a] = 16'(a * 7 + 3);
        end
        mem0[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
        fs0.adr = 0; fs0.dto = 0; fs0.stb = 0; fs0.wre = 0;
        ab0.adr = 0; ab0.dto = 0; ab0.stb = 0; ab0.wre = 0;
        fs1.adr = 0; fs1.dto = 0; fs1.stb = 0; fs1.wre = 0;
        ab1.adr = 0; ab1.dto = 0; ab1.stb = 0; ab1.wre = 0;
        repeat (2) @(negedge clk);
        test_reset;
        test_fs_read;
        test_ab_write;
        test_random;
        test_spurious_ack;
        test_drop_stb;
        test_timeout;
        test_contention;
        test_fixp;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
